// File: rtl/mealy_multi_pattern_detector_pkg.sv
// Shared constants and helpers for the multi-pattern serial detector.
package mealy_pkg;

  localparam int unsigned WORD_W = 32;

  // Reset contents of pattern slots 0 and 1, truncated to PAT_LEN by the user.
  localparam logic [WORD_W-1:0] DEFAULT_PAT0 = '1;
  localparam logic [WORD_W-1:0] DEFAULT_PAT1 = WORD_W'(1);

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Saturating increment of a w-bit value carried in a WORD_W container.
  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v, input int unsigned w);
    logic [WORD_W-1:0] top_val;
    top_val = (w >= WORD_W) ? '1 : ((WORD_W'(1) << w) - WORD_W'(1));
    return (v >= top_val) ? v : v + WORD_W'(1);
  endfunction

endpackage

// File: rtl/mealy_multi_pattern_detector_if.sv
// Stream, configuration and status bundle of the multi-pattern detector.
interface mealy_multi_pattern_detector_if
  import mealy_pkg::*;
#(
  parameter int unsigned PAT_LEN = 3,
  parameter int unsigned NUM_PAT = 2,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned IDX_W = idx_w(NUM_PAT);

  logic                       valid_in;
  logic                       i;
  logic                       clear;
  logic                       cfg_we;
  logic [IDX_W-1:0]           cfg_idx;
  logic [PAT_LEN-1:0]         cfg_pat;
  logic [NUM_PAT-1:0]         o;
  logic                       any_match;
  logic [NUM_PAT*CNT_W-1:0]   hit_cnt;

  modport master (
    output valid_in, i, clear, cfg_we, cfg_idx, cfg_pat,
    input  o, any_match, hit_cnt
  );

  modport slave (
    input  valid_in, i, clear, cfg_we, cfg_idx, cfg_pat,
    output o, any_match, hit_cnt
  );

endinterface

// File: rtl/mealy_multi_pattern_detector_window.sv
// Shift history of previous stream bits plus fill count; exports the candidate word.
module pattern_window
  import mealy_pkg::*;
#(
  parameter int unsigned PAT_LEN = 3,
  parameter int unsigned OVERLAP = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               valid_in,
  input  logic               bit_in,
  input  logic               clear,
  input  logic               flush,
  output logic [PAT_LEN-1:0] cand_c,
  output logic               full_c
);

  localparam int unsigned HIST_W   = PAT_LEN - 1;
  localparam int unsigned FILL_W   = idx_w(PAT_LEN);
  localparam int unsigned FULL_CNT = PAT_LEN - 1;

  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  assign cand_c = {hist_q, bit_in};
  assign full_c = (fill_q == FILL_W'(FULL_CNT));

  // Clear dominates; in non-overlap mode a match restarts the window from empty.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (valid_in) begin
      if ((OVERLAP == 0) && flush) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = cand_c[HIST_W-1:0];
        fill_d = full_c ? fill_q : fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/mealy_multi_pattern_detector.sv
// Mealy detector comparing a qualified serial stream against a programmable pattern bank,
// with per-pattern saturating hit counters.
module mealy_multi_pattern_detector
  import mealy_pkg::*;
#(
  parameter int unsigned PAT_LEN = 3,
  parameter int unsigned NUM_PAT = 2,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned OVERLAP = 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  mealy_multi_pattern_detector_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(NUM_PAT);

  logic [PAT_LEN-1:0] pattern_q [NUM_PAT];
  logic [CNT_W-1:0]   cnt_q     [NUM_PAT];
  logic [PAT_LEN-1:0] cand_c;
  logic               full_c;
  logic               qualified_c;
  logic [NUM_PAT-1:0] match_c;

  pattern_window #(
    .PAT_LEN (PAT_LEN),
    .OVERLAP (OVERLAP)
  ) u_window (
    .clock    (clock),
    .reset_n  (reset_n),
    .valid_in (bus.valid_in),
    .bit_in   (bus.i),
    .clear    (bus.clear),
    .flush    (bus.any_match),
    .cand_c   (cand_c),
    .full_c   (full_c)
  );

  // Flags are purely combinational from the current bit and the registered window.
  assign qualified_c = bus.valid_in & ~bus.clear & full_c;

  always_comb begin
    match_c = '0;
    for (int unsigned k = 0; k < NUM_PAT; k++) begin
      match_c[k] = qualified_c && (cand_c == pattern_q[k]);
    end
  end

  assign bus.o         = match_c;
  assign bus.any_match = |match_c;

  // Pattern bank; a write lands at the edge so the current compare sees the old value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NUM_PAT; k++) begin
        if (k == 0)      pattern_q[k] <= PAT_LEN'(DEFAULT_PAT0);
        else if (k == 1) pattern_q[k] <= PAT_LEN'(DEFAULT_PAT1);
        else             pattern_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_PAT; k++) begin
        if (bus.cfg_we && (bus.cfg_idx == IDX_W'(k))) begin
          pattern_q[k] <= bus.cfg_pat;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NUM_PAT; k++) cnt_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_PAT; k++) begin
        if (bus.clear)       cnt_q[k] <= '0;
        else if (match_c[k]) cnt_q[k] <= CNT_W'(sat_inc(WORD_W'(cnt_q[k]), CNT_W));
      end
    end
  end

  always_comb begin
    bus.hit_cnt = '0;
    for (int unsigned k = 0; k < NUM_PAT; k++) begin
      bus.hit_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end

endmodule

// File: tb/tb_mealy_multi_pattern_detector.sv
// Directed bench: three detector instances (overlap, non-overlap, 2-bit counters) share one stream.
module tb_mealy_multi_pattern_detector;

  logic       clock;
  logic       rst_n;
  logic       vin, bin, clr, we;
  logic       widx;
  logic [2:0] wpat;

  int vectors     = 0;
  int miscompares = 0;

  mealy_multi_pattern_detector_if #(.PAT_LEN(3), .NUM_PAT(2), .CNT_W(8)) bus_a ();
  mealy_multi_pattern_detector_if #(.PAT_LEN(3), .NUM_PAT(2), .CNT_W(8)) bus_b ();
  mealy_multi_pattern_detector_if #(.PAT_LEN(3), .NUM_PAT(2), .CNT_W(2)) bus_c ();

  assign bus_a.valid_in = vin;  assign bus_b.valid_in = vin;  assign bus_c.valid_in = vin;
  assign bus_a.i        = bin;  assign bus_b.i        = bin;  assign bus_c.i        = bin;
  assign bus_a.clear    = clr;  assign bus_b.clear    = clr;  assign bus_c.clear    = clr;
  assign bus_a.cfg_we   = we;   assign bus_b.cfg_we   = we;   assign bus_c.cfg_we   = we;
  assign bus_a.cfg_idx  = widx; assign bus_b.cfg_idx  = widx; assign bus_c.cfg_idx  = widx;
  assign bus_a.cfg_pat  = wpat; assign bus_b.cfg_pat  = wpat; assign bus_c.cfg_pat  = wpat;

  mealy_multi_pattern_detector #(.PAT_LEN(3), .NUM_PAT(2), .CNT_W(8), .OVERLAP(1)) dut_a (
    .clock(clock), .reset_n(rst_n), .bus(bus_a));
  mealy_multi_pattern_detector #(.PAT_LEN(3), .NUM_PAT(2), .CNT_W(8), .OVERLAP(0)) dut_b (
    .clock(clock), .reset_n(rst_n), .bus(bus_b));
  mealy_multi_pattern_detector #(.PAT_LEN(3), .NUM_PAT(2), .CNT_W(2), .OVERLAP(1)) dut_c (
    .clock(clock), .reset_n(rst_n), .bus(bus_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 ns later.
  task automatic step(input logic v, input logic b);
    @(negedge clock);
    vin = v; bin = b; clr = 1'b0; we = 1'b0;
    #2;
  endtask

  // Bit/valid vectors and expected flag pairs are written first-applied-first (MSB side).
  task automatic stream(input string tag, input int n, input logic [15:0] vb, input logic [15:0] bb,
                        input logic [31:0] ea, input logic [31:0] eb);
    for (int j = 0; j < n; j++) begin
      int p;
      p = n - 1 - j;
      step(vb[p], bb[p]);
      chk($sformatf("%s a.o[%0d]", tag, j), 32'(bus_a.o), 32'(ea[2*p +: 2]));
      chk($sformatf("%s a.any[%0d]", tag, j), 32'(bus_a.any_match), 32'(|ea[2*p +: 2]));
      chk($sformatf("%s b.o[%0d]", tag, j), 32'(bus_b.o), 32'(eb[2*p +: 2]));
      chk($sformatf("%s c.o[%0d]", tag, j), 32'(bus_c.o), 32'(ea[2*p +: 2]));
    end
  endtask

  task automatic clear_cycle(input string tag, input logic v);
    @(negedge clock);
    vin = v; bin = 1'b1; clr = 1'b1; we = 1'b0;
    #2;
    chk({tag, " a.o"}, 32'(bus_a.o), 32'd0);
    chk({tag, " b.o"}, 32'(bus_b.o), 32'd0);
    chk({tag, " c.o"}, 32'(bus_c.o), 32'd0);
  endtask

  task automatic counts(input string tag, input logic [15:0] ca, input logic [15:0] cb,
                        input logic [3:0] cc);
    step(1'b0, 1'b0);
    chk({tag, " a.hit_cnt"}, 32'(bus_a.hit_cnt), 32'(ca));
    chk({tag, " b.hit_cnt"}, 32'(bus_b.hit_cnt), 32'(cb));
    chk({tag, " c.hit_cnt"}, 32'(bus_c.hit_cnt), 32'(cc));
  endtask

  initial begin
    rst_n = 1'b0; vin = 1'b0; bin = 1'b0; clr = 1'b0; we = 1'b0; widx = 1'b0; wpat = 3'b000;
    repeat (2) @(negedge clock);
    #2;
    chk("reset a.o", 32'(bus_a.o), 32'd0);
    chk("reset a.any", 32'(bus_a.any_match), 32'd0);
    chk("reset a.hit_cnt", 32'(bus_a.hit_cnt), 32'd0);
    chk("reset c.hit_cnt", 32'(bus_c.hit_cnt), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;

    // Default patterns 111 and 001
    stream("t1", 10, 16'hFFFF, 16'(10'b1110011001),
           32'(20'b00_00_01_00_00_10_00_00_00_10), 32'(20'b00_00_01_00_00_10_00_00_00_10));
    counts("t1", 16'h0201, 16'h0201, 4'b1001);
    clear_cycle("t1 clear", 1'b0);
    counts("t1 cleared", 16'h0000, 16'h0000, 4'b0000);

    // Overlap vs flush on a run of ones; 2-bit counter saturates at 3
    stream("t2", 6, 16'hFFFF, 16'(6'b111111),
           32'(12'b00_00_01_01_01_01), 32'(12'b00_00_01_00_00_01));
    counts("t2", 16'h0004, 16'h0002, 4'b0011);

    // Gaps in valid_in hold the window
    clear_cycle("t3 clear", 1'b0);
    stream("t3", 6, 16'(6'b100011), 16'(6'b111111),
           32'(12'b00_00_00_00_00_01), 32'(12'b00_00_00_00_00_01));

    // Pattern write on the final bit only takes effect next cycle
    clear_cycle("t4 clear", 1'b0);
    stream("t4 pre", 2, 16'hFFFF, 16'(2'b10), 32'd0, 32'd0);
    @(negedge clock);
    vin = 1'b1; bin = 1'b1; clr = 1'b0; we = 1'b1; widx = 1'b1; wpat = 3'b101;
    #2;
    chk("t4 write-cycle a.o", 32'(bus_a.o), 32'd0);
    chk("t4 write-cycle b.o", 32'(bus_b.o), 32'd0);
    stream("t4", 3, 16'hFFFF, 16'(3'b101), 32'(6'b00_00_10), 32'(6'b00_00_10));

    // Seven matches, clear beating a matching bit, then refill
    clear_cycle("t5 clear", 1'b0);
    stream("t5", 9, 16'hFFFF, 16'(9'b111111111),
           32'(18'b00_00_01_01_01_01_01_01_01), 32'(18'b00_00_01_00_00_01_00_00_01));
    counts("t5 sat", 16'h0007, 16'h0003, 4'b0011);
    clear_cycle("t5 clear-beats-valid", 1'b1);
    counts("t5 cleared", 16'h0000, 16'h0000, 4'b0000);
    stream("t5 refill", 3, 16'hFFFF, 16'(3'b111), 32'(6'b00_00_01), 32'(6'b00_00_01));

    // Mid-stream reset discards window, counters and programmed pattern
    stream("t6 pre", 4, 16'hFFFF, 16'(4'b0011), 32'd0, 32'd0);
    @(negedge clock);
    vin = 1'b0; rst_n = 1'b0;
    #2;
    chk("t6 reset a.hit_cnt", 32'(bus_a.hit_cnt), 32'd0);
    chk("t6 reset b.hit_cnt", 32'(bus_b.hit_cnt), 32'd0);
    chk("t6 reset c.hit_cnt", 32'(bus_c.hit_cnt), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    stream("t6", 6, 16'hFFFF, 16'(6'b111001),
           32'(12'b00_00_01_00_00_10), 32'(12'b00_00_01_00_00_10));
    counts("t6", 16'h0101, 16'h0101, 4'b0101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
